riscv_single_cycle_core: RTL and testbench

//   Single-cycle RV64 integer core (subset): fetch, decode, execute, memory and writeback in one clock.

---
 rtl/riscv_single_cycle_core.sv | 231 +++++++++++++++++++++++
 tb/tb_riscv_single_cycle_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_single_cycle_core.sv
// Single-cycle RV64 integer subset core: built-in instruction ROM, 32x64 register file,
// ALU and byte-addressed data RAM, with every datapath node exported for debug.
module riscv_single_cycle_core #(
  parameter int IMEM_BYTES     = 256,
  parameter int DMEM_BYTES     = 256,
  parameter     IMEM_INIT_FILE = "",
  parameter     DMEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] pc_out,
  output logic [63:0] adder1_out,
  output logic [63:0] adder2_out,
  output logic [63:0] pc_in,
  output logic        zero,
  output logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [63:0] writeData,
  output logic [63:0] readdata1,
  output logic [63:0] readdata2,
  output logic        branch,
  output logic        memread,
  output logic        memtoreg,
  output logic        memwrite,
  output logic        alusrc,
  output logic        regwrite,
  output logic [1:0]  aluop,
  output logic [63:0] immdata,
  output logic [63:0] mux2out,
  output logic [3:0]  operation,
  output logic [63:0] aluout,
  output logic [63:0] datamemoryreaddata,
  output logic [63:0] element1,
  output logic [63:0] element2,
  output logic [63:0] element3,
  output logic [63:0] element4,
  output logic [63:0] element5,
  output logic [63:0] element6,
  output logic [63:0] element7,
  output logic [63:0] element8
);

  localparam int IAW = $clog2(IMEM_BYTES);
  localparam int DAW = $clog2(DMEM_BYTES);

  logic [63:0] pc_q, pc_d;
  logic [63:0] rf_q [32];
  logic [7:0]  imem_mem [IMEM_BYTES];
  logic [7:0]  dmem_q [DMEM_BYTES];
  logic        rf_we_d;
  logic        dmem_we_d;
  logic        taken_s;
  logic [63:0] elem_s [8];

  // Memory images: unloaded bytes stay zero.
  initial begin
    for (int i = 0; i < IMEM_BYTES; i++) imem_mem[i] = 8'h00;
    for (int i = 0; i < DMEM_BYTES; i++) dmem_q[i] = 8'h00;
  end

  assign pc_out     = pc_q;
  assign adder1_out = pc_q + 64'd4;
  assign adder2_out = pc_q + (immdata << 1);

  always_comb begin
    instruction = 32'd0;
    for (int k = 0; k < 4; k++)
      instruction[8*k +: 8] = imem_mem[IAW'(pc_q[IAW-1:0] + IAW'(k))];
  end

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  always_comb begin
    branch   = 1'b0;
    memread  = 1'b0;
    memtoreg = 1'b0;
    memwrite = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    aluop    = 2'b00;
    immdata  = 64'd0;
    case (opcode)
      7'b0110011: begin
        regwrite = 1'b1;
        aluop    = 2'b10;
      end
      7'b0010011: begin
        alusrc   = 1'b1;
        regwrite = 1'b1;
        immdata  = {{52{instruction[31]}}, instruction[31:20]};
      end
      7'b0000011: begin
        alusrc   = 1'b1;
        memread  = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
        immdata  = {{52{instruction[31]}}, instruction[31:20]};
      end
      7'b0100011: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
        immdata  = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      7'b1100011: begin
        branch  = 1'b1;
        aluop   = 2'b01;
        // Halfword-scaled offset; adder2 applies the final shift.
        immdata = {{52{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8]};
      end
      default: begin
        regwrite = 1'b0;
      end
    endcase
  end

  always_comb begin
    operation = 4'b0010;
    case (aluop)
      2'b01: operation = 4'b0110;
      2'b10: begin
        case ({funct7[5], funct3})
          4'b0_000: operation = 4'b0010;
          4'b1_000: operation = 4'b0110;
          4'b0_111: operation = 4'b0000;
          4'b0_110: operation = 4'b0001;
          default:  operation = 4'b0010;
        endcase
      end
      default: operation = 4'b0010;
    endcase
  end

  assign readdata1 = (rs1 == 5'd0) ? 64'd0 : rf_q[rs1];
  assign readdata2 = (rs2 == 5'd0) ? 64'd0 : rf_q[rs2];
  assign mux2out   = alusrc ? immdata : readdata2;

  always_comb begin
    aluout = 64'd0;
    case (operation)
      4'b0000: aluout = readdata1 & mux2out;
      4'b0001: aluout = readdata1 | mux2out;
      4'b0010: aluout = readdata1 + mux2out;
      4'b0110: aluout = readdata1 - mux2out;
      4'b1100: aluout = ~(readdata1 | mux2out);
      default: aluout = 64'd0;
    endcase
  end

  assign zero = (aluout == 64'd0);

  always_comb begin
    taken_s = 1'b0;
    if (branch) begin
      case (funct3)
        3'b000:  taken_s = zero;
        3'b001:  taken_s = ~zero;
        3'b100:  taken_s = aluout[63];
        default: taken_s = 1'b0;
      endcase
    end else begin
      taken_s = 1'b0;
    end
  end

  assign pc_in = taken_s ? adder2_out : adder1_out;

  // Load path: each byte index wraps independently, so misaligned reads work.
  always_comb begin
    datamemoryreaddata = 64'd0;
    if (memread) begin
      for (int k = 0; k < 8; k++)
        datamemoryreaddata[8*k +: 8] = dmem_q[DAW'(aluout[DAW-1:0] + DAW'(k))];
    end else begin
      datamemoryreaddata = 64'd0;
    end
  end

  assign writeData = memtoreg ? datamemoryreaddata : aluout;

  always_comb begin
    for (int e = 0; e < 8; e++) begin
      elem_s[e] = 64'd0;
      for (int b = 0; b < 8; b++)
        elem_s[e][8*b +: 8] = dmem_q[DAW'(8*e + b)];
    end
  end

  assign element1 = elem_s[0];
  assign element2 = elem_s[1];
  assign element3 = elem_s[2];
  assign element4 = elem_s[3];
  assign element5 = elem_s[4];
  assign element6 = elem_s[5];
  assign element7 = elem_s[6];
  assign element8 = elem_s[7];

  always_comb begin
    pc_d      = pc_in;
    rf_we_d   = regwrite && (rd != 5'd0);
    dmem_we_d = memwrite && reset;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= 64'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 64'd0;
    end else begin
      pc_q <= pc_d;
      if (rf_we_d) rf_q[rd] <= writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (dmem_we_d) begin
      for (int k = 0; k < 8; k++)
        dmem_q[DAW'(aluout[DAW-1:0] + DAW'(k))] <= readdata2[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// Directed program for riscv_single_cycle_core: ALU, load/store, branches, x0 and reset,
// with every expected value worked out by hand from the instruction stream below.
module tb_riscv_single_cycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] pc_out, adder1_out, adder2_out, pc_in;
  logic        zero;
  logic [31:0] instruction;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [63:0] writeData, readdata1, readdata2, immdata, mux2out, aluout, datamemoryreaddata;
  logic        branch, memread, memtoreg, memwrite, alusrc, regwrite;
  logic [1:0]  aluop;
  logic [3:0]  operation;
  logic [63:0] element1, element2, element3, element4, element5, element6, element7, element8;

  int total = 0;
  int bad   = 0;

  riscv_single_cycle_core dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .adder1_out(adder1_out),
    .adder2_out(adder2_out), .pc_in(pc_in), .zero(zero), .instruction(instruction),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .writeData(writeData), .readdata1(readdata1), .readdata2(readdata2),
    .branch(branch), .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite),
    .alusrc(alusrc), .regwrite(regwrite), .aluop(aluop), .immdata(immdata),
    .mux2out(mux2out), .operation(operation), .aluout(aluout),
    .datamemoryreaddata(datamemoryreaddata),
    .element1(element1), .element2(element2), .element3(element3), .element4(element4),
    .element5(element5), .element6(element6), .element7(element7), .element8(element8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.imem_mem[addr + k] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] s2,
                                        input logic [4:0] s1);
    return {imm[11:5], s2, s1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3);
    return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  initial begin
    #1;
    put(0,  enc_r(7'h00, 5'd8, 5'd3, 3'd0, 5'd12));          // add x12,x3,x8
    put(4,  32'h00500093);                                  // addi x1,x0,5
    put(8,  enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2));           // add x2,x1,x1
    put(12, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));           // sub x3,x1,x2
    put(16, enc_i(12'd12, 5'd0, 3'd0, 5'd5, 7'h13));         // addi x5,x0,12
    put(20, enc_i(12'd10, 5'd0, 3'd0, 5'd6, 7'h13));         // addi x6,x0,10
    put(24, enc_r(7'h00, 5'd6, 5'd5, 3'd7, 5'd7));           // and x7,x5,x6
    put(28, enc_r(7'h00, 5'd6, 5'd5, 3'd6, 5'd8));           // or  x8,x5,x6
    put(32, enc_s(12'd8, 5'd2, 5'd0));                       // sd x2,8(x0)
    put(36, enc_i(12'd8, 5'd0, 3'd3, 5'd4, 7'h03));          // ld x4,8(x0)
    put(40, enc_i(12'hFFE, 5'd4, 3'd0, 5'd9, 7'h13));        // addi x9,x4,-2
    put(44, enc_b(13'd8, 5'd1, 5'd1, 3'd0));                 // beq x1,x1,+8
    put(48, enc_i(12'd1, 5'd0, 3'd0, 5'd10, 7'h13));         // skipped
    put(52, enc_b(13'd8, 5'd1, 5'd1, 3'd1));                 // bne x1,x1,+8
    put(56, enc_b(13'd8, 5'd1, 5'd3, 3'd4));                 // blt x3,x1,+8
    put(60, enc_i(12'd2, 5'd0, 3'd0, 5'd10, 7'h13));         // skipped
    put(64, enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13));          // addi x0,x0,7
    put(68, 32'h00000000);                                  // all-zero nop
    put(72, enc_r(7'h00, 5'd10, 5'd0, 3'd0, 5'd11));         // add x11,x0,x10
    put(76, enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0));              // beq x0,x0,-8

    reset = 1'b0;
    step();
    step();
    chk("rst_pc", pc_out, 64'd0);
    chk("rst_adder1", adder1_out, 64'd4);
    chk("rst_rd1", readdata1, 64'd0);
    reset = 1'b1;

    step();
    chk("pc4", pc_out, 64'd4);
    chk("addi_inst", {32'd0, instruction}, 64'h00500093);
    chk("addi_imm", immdata, 64'd5);
    chk("addi_wd", writeData, 64'd5);
    chk("addi_ctl", {58'd0, alusrc, regwrite, memread, memwrite, aluop}, {58'd0, 6'b110000});

    step();
    chk("pc8", pc_out, 64'd8);
    chk("add_wd", writeData, 64'd10);

    step();
    chk("pc12", pc_out, 64'd12);
    chk("sub_rd2", readdata2, 64'd10);
    chk("sub_alu", aluout, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("sub_op", {60'd0, operation}, {60'd0, 4'b0110});

    step();
    step();
    step();
    chk("and_alu", aluout, 64'd8);
    chk("and_op", {60'd0, operation}, 64'd0);
    step();
    chk("or_alu", aluout, 64'hE);
    chk("or_op", {60'd0, operation}, 64'd1);

    step();
    chk("sd_pc", pc_out, 64'd32);
    chk("sd_memwrite", {63'd0, memwrite}, 64'd1);
    chk("sd_regwrite", {63'd0, regwrite}, 64'd0);
    chk("sd_imm", immdata, 64'd8);
    chk("sd_elem2_old", element2, 64'd0);

    step();
    chk("sd_elem2_new", element2, 64'd10);
    chk("ld_memread", {63'd0, memread}, 64'd1);
    chk("ld_data", datamemoryreaddata, 64'd10);
    chk("ld_wd", writeData, 64'd10);

    step();
    chk("x4_value", readdata1, 64'd10);
    chk("nold_alu", aluout, 64'd8);
    chk("nold_gate", datamemoryreaddata, 64'd0);
    chk("nold_wd", writeData, 64'd8);

    step();
    chk("beq_pc", pc_out, 64'd44);
    chk("beq_zero", {63'd0, zero}, 64'd1);
    chk("beq_tgt", adder2_out, 64'd52);
    chk("beq_pcin", pc_in, 64'd52);

    step();
    chk("bne_pc", pc_out, 64'd52);
    chk("bne_pcin", pc_in, 64'd56);

    step();
    chk("blt_rd1", readdata1, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("blt_alu", aluout, 64'hFFFF_FFFF_FFFF_FFF6);
    chk("blt_pcin", pc_in, 64'd64);

    step();
    chk("x0w_pc", pc_out, 64'd64);
    chk("x0w_wd", writeData, 64'd7);

    step();
    chk("nop_rd1", readdata1, 64'd0);
    chk("nop_ctl", {58'd0, branch, memread, memtoreg, memwrite, alusrc, regwrite}, 64'd0);
    chk("nop_imm", immdata, 64'd0);
    chk("nop_pcin", pc_in, 64'd72);

    step();
    chk("x10_untouched", readdata2, 64'd0);
    chk("x0_stays", readdata1, 64'd0);

    step();
    chk("back_pc", pc_out, 64'd76);
    chk("back_tgt", pc_in, 64'd68);
    step();
    chk("back_land", pc_out, 64'd68);

    reset = 1'b0;
    step();
    chk("mid_rst_pc", pc_out, 64'd0);
    chk("mid_rst_x3", readdata1, 64'd0);
    chk("mid_rst_x8", readdata2, 64'd0);
    chk("mid_rst_elem2", element2, 64'd10);
    chk("mid_rst_elem1", element1, 64'd0);
    reset = 1'b1;
    step();
    chk("post_rst_pc", pc_out, 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
